// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the MEM pipeline register and riscv_dmem.
// Ports:
//   i_clk, i_rstn                 clock, async active-low reset
//   i_req_* / o_req_ready         request (we, funct3, addr, wdata, rd)
//   o_rsp_* / i_rsp_ready         response (rdata, rd, is_load, err)
//   o_dmem_* / i_dmem_data        word-addressed dmem port, one cycle per request
module riscv_lsu #(
    parameter int XLEN          = 32,
    parameter int DMEM_ADDR_BIT = 13
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_we,
    input  logic [2:0]               i_req_funct3,
    input  logic [XLEN-1:0]          i_req_addr,
    input  logic [XLEN-1:0]          i_req_wdata,
    input  logic [4:0]               i_req_rd,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [XLEN-1:0]          o_rsp_rdata,
    output logic [4:0]               o_rsp_rd,
    output logic                     o_rsp_is_load,
    output logic                     o_rsp_err,
    output logic [XLEN-1:0]          o_dmem_data,
    input  logic [XLEN-1:0]          i_dmem_data,
    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic [XLEN/8-1:0]        o_dmem_byte_sel,
    output logic                     o_dmem_wr_en
);
    localparam int NB = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                     req_we;
    logic [2:0]               req_f3;
    logic [DMEM_ADDR_BIT-1:0] req_addr;
    logic [XLEN-1:0]          req_wdata;
    logic [4:0]               req_rd;

    logic            illegal;
    logic            misal;
    logic            req_err;
    logic [NB-1:0]   sel;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext;
    logic            unused_addr;

    assign unused_addr = ^i_req_addr[XLEN-1:DMEM_ADDR_BIT];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Request registers also feed dmem addr/data, so those hold between requests.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            req_we    <= 1'b0;
            req_f3    <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_rd    <= '0;
        end else if (i_req_valid && state == IDLE) begin
            req_we    <= i_req_we;
            req_f3    <= i_req_funct3;
            req_addr  <= i_req_addr[DMEM_ADDR_BIT-1:0];
            req_wdata <= i_req_wdata;
            req_rd    <= i_req_rd;
        end
    end

    always_comb begin
        if (req_we) illegal = req_f3[2] || (req_f3[1:0] == 2'b11);
        else        illegal = (req_f3 == 3'b011) || (req_f3[2:1] == 2'b11);
    end

    always_comb begin
        misal = 1'b0;
        if (req_f3[1:0] == 2'b01) misal = req_addr[0];
        if (req_f3[1:0] == 2'b10) misal = (req_addr[1:0] != 2'b00);
    end

    assign req_err = illegal || misal;

    always_comb begin
        sel         = {NB{1'b1}};
        o_dmem_data = req_wdata;
        case (req_f3[1:0])
            2'b00: begin
                sel         = NB'(1) << req_addr[1:0];
                o_dmem_data = {NB{req_wdata[7:0]}};
            end
            2'b01: begin
                sel         = NB'(3) << req_addr[1:0];
                o_dmem_data = {(NB/2){req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign o_dmem_addr = req_addr[DMEM_ADDR_BIT-1:2];

    assign shifted = i_dmem_data >> {req_addr[1:0], 3'b000};

    always_comb begin
        case (req_f3)
            3'b000:  ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b001:  ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    // Strobes are decoded from state so an async reset in ACCESS kills them at once.
    always_comb begin
        state_nxt       = state;
        o_req_ready     = 1'b0;
        o_rsp_valid     = 1'b0;
        o_dmem_wr_en    = 1'b0;
        o_dmem_byte_sel = '0;
        unique case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) state_nxt = ACCESS;
            end
            ACCESS: begin
                o_dmem_wr_en = req_we && !req_err;
                if (req_we && !req_err) o_dmem_byte_sel = sel;
                state_nxt = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rsp_rdata   <= '0;
            o_rsp_rd      <= '0;
            o_rsp_is_load <= 1'b0;
            o_rsp_err     <= 1'b0;
        end else if (state == ACCESS) begin
            o_rsp_rdata   <= (!req_we && !req_err) ? ext : '0;
            o_rsp_rd      <= req_rd;
            o_rsp_is_load <= !req_we;
            o_rsp_err     <= req_err;
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed bench for riscv_lsu with a behavioural word memory.
// Ports: none (top-level bench).
module tb_riscv_lsu;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_f3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_is_load;
    logic        rsp_err;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [10:0] dmem_addr;
    logic [3:0]  dmem_sel;
    logic        dmem_we;

    logic [31:0] mem [0:2047];

    int checks = 0;
    int errors = 0;

    logic        a_we;
    logic [3:0]  a_sel;
    logic [31:0] a_data;
    logic [10:0] a_addr;
    logic        a_valid;
    logic        r_we;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic [4:0]  r_rd;
    logic        r_load;
    logic        r_err;

    always #5 clk = ~clk;

    riscv_lsu dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_we        (req_we),
        .i_req_funct3    (req_f3),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .i_req_rd        (req_rd),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .o_rsp_rdata     (rsp_rdata),
        .o_rsp_rd        (rsp_rd),
        .o_rsp_is_load   (rsp_is_load),
        .o_rsp_err       (rsp_err),
        .o_dmem_data     (dmem_wdata),
        .i_dmem_data     (dmem_rdata),
        .o_dmem_addr     (dmem_addr),
        .o_dmem_byte_sel (dmem_sel),
        .o_dmem_wr_en    (dmem_we)
    );

    assign dmem_rdata = mem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_we) begin
            for (int b = 0; b < 4; b++)
                if (dmem_sel[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
    end

    // Drive one request, snapshot the ACCESS and RESP cycles, leave rsp unconsumed.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_f3    = f3;
        req_addr  = a;
        req_wdata = wd;
        req_rd    = rd;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout ready=%0b want 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_f3    = 3'b111;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h1234_5678;
        req_rd    = 5'd31;
        a_we    = dmem_we;
        a_sel   = dmem_sel;
        a_data  = dmem_wdata;
        a_addr  = dmem_addr;
        a_valid = rsp_valid;
        @(posedge clk);
        #1;
        r_we    = dmem_we;
        r_valid = rsp_valid;
        r_rdata = rsp_rdata;
        r_rd    = rsp_rd;
        r_load  = rsp_is_load;
        r_err   = rsp_err;
    endtask

    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL consume valid=%0b ready=%0b want 0/1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready got %0b want 1", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid);
        end
        checks++;
        if ({rsp_rdata, rsp_rd, rsp_is_load, rsp_err} !== '0) begin
            errors++;
            $display("FAIL rst_rsp got %h/%0d/%0b/%0b want 0",
                     rsp_rdata, rsp_rd, rsp_is_load, rsp_err);
        end
        checks++;
        if (dmem_addr !== 11'd0 || dmem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_dmem got %h/%h want 0", dmem_addr, dmem_wdata);
        end
        checks++;
        if (dmem_we !== 1'b0 || dmem_sel !== 4'b0) begin
            errors++;
            $display("FAIL rst_strobe got %0b/%b want 0", dmem_we, dmem_sel);
        end
    endtask

    task automatic test_word();
        issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd3);
        checks++;
        if (a_we !== 1'b1 || a_sel !== 4'b1111) begin
            errors++; $display("FAIL sw_strobe got %0b/%b want 1/1111", a_we, a_sel);
        end
        checks++;
        if (a_addr !== 11'h040 || a_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_port got %h/%h want 040/deadbeef", a_addr, a_data);
        end
        checks++;
        if (r_we !== 1'b0 || r_valid !== 1'b1 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL sw_timing got we=%0b v=%0b early=%0b want 0/1/0",
                     r_we, r_valid, a_valid);
        end
        checks++;
        if (r_rdata !== 32'd0 || r_load !== 1'b0 || r_err !== 1'b0 || r_rd !== 5'd3) begin
            errors++;
            $display("FAIL sw_rsp got %h/%0b/%0b/%0d want 0/0/0/3",
                     r_rdata, r_load, r_err, r_rd);
        end
        checks++;
        if (mem[11'h040] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL sw_mem got %h want deadbeef", mem[11'h040]);
        end
        consume();
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
        checks++;
        if (a_we !== 1'b0 || a_sel !== 4'b0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL lw_access got %0b/%b/%0b want 0/0000/0", a_we, a_sel, a_valid);
        end
        checks++;
        if (r_valid !== 1'b1 || r_rdata !== 32'hDEAD_BEEF || r_rd !== 5'd5 || r_load !== 1'b1) begin
            errors++;
            $display("FAIL lw_rsp got %0b/%h/%0d/%0b want 1/deadbeef/5/1",
                     r_valid, r_rdata, r_rd, r_load);
        end
        consume();
    endtask

    task automatic test_byte();
        issue(1'b1, 3'b000, 32'h103, 32'h0000_0080, 5'd0);
        checks++;
        if (a_sel !== 4'b1000 || a_data !== 32'h8080_8080) begin
            errors++;
            $display("FAIL sb_port got %b/%h want 1000/80808080", a_sel, a_data);
        end
        checks++;
        if (mem[11'h040] !== 32'h80AD_BEEF) begin
            errors++; $display("FAIL sb_mem got %h want 80adbeef", mem[11'h040]);
        end
        consume();
        issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd1);
        checks++;
        if (r_rdata !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb got %h want ffffff80", r_rdata);
        end
        consume();
        issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd2);
        checks++;
        if (r_rdata !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu got %h want 00000080", r_rdata);
        end
        consume();
        issue(1'b0, 3'b000, 32'h101, 32'h0, 5'd2);
        checks++;
        if (r_rdata !== 32'hFFFF_FFBE) begin
            errors++; $display("FAIL lb_lane1 got %h want ffffffbe", r_rdata);
        end
        consume();
    endtask

    task automatic test_half();
        issue(1'b1, 3'b001, 32'h102, 32'h0000_8001, 5'd0);
        checks++;
        if (a_sel !== 4'b1100 || a_data !== 32'h8001_8001) begin
            errors++;
            $display("FAIL sh_port got %b/%h want 1100/80018001", a_sel, a_data);
        end
        checks++;
        if (mem[11'h040] !== 32'h8001_BEEF) begin
            errors++; $display("FAIL sh_mem got %h want 8001beef", mem[11'h040]);
        end
        consume();
        issue(1'b0, 3'b001, 32'h102, 32'h0, 5'd4);
        checks++;
        if (r_rdata !== 32'hFFFF_8001) begin
            errors++; $display("FAIL lh got %h want ffff8001", r_rdata);
        end
        consume();
        issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd4);
        checks++;
        if (r_rdata !== 32'h0000_8001) begin
            errors++; $display("FAIL lhu got %h want 00008001", r_rdata);
        end
        consume();
        issue(1'b0, 3'b001, 32'h100, 32'h0, 5'd4);
        checks++;
        if (r_rdata !== 32'hFFFF_BEEF) begin
            errors++; $display("FAIL lh_low got %h want ffffbeef", r_rdata);
        end
        consume();
    endtask

    task automatic test_errors();
        issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd9);
        checks++;
        if (r_err !== 1'b1 || r_rdata !== 32'd0 || r_load !== 1'b1 || r_rd !== 5'd9) begin
            errors++;
            $display("FAIL lw_misal got %0b/%h/%0b/%0d want 1/0/1/9",
                     r_err, r_rdata, r_load, r_rd);
        end
        consume();
        issue(1'b1, 3'b001, 32'h101, 32'h0000_FFFF, 5'd0);
        checks++;
        if (a_we !== 1'b0 || a_sel !== 4'b0 || r_err !== 1'b1) begin
            errors++;
            $display("FAIL sh_misal got %0b/%b/%0b want 0/0000/1", a_we, a_sel, r_err);
        end
        consume();
        issue(1'b1, 3'b011, 32'h100, 32'h5555_5555, 5'd0);
        checks++;
        if (a_we !== 1'b0 || r_err !== 1'b1 || r_rdata !== 32'd0) begin
            errors++;
            $display("FAIL st_f3_011 got %0b/%0b/%h want 0/1/0", a_we, r_err, r_rdata);
        end
        consume();
        issue(1'b0, 3'b110, 32'h100, 32'h0, 5'd0);
        checks++;
        if (r_err !== 1'b1 || r_rdata !== 32'd0) begin
            errors++; $display("FAIL ld_f3_110 got %0b/%h want 1/0", r_err, r_rdata);
        end
        consume();
        checks++;
        if (mem[11'h040] !== 32'h8001_BEEF) begin
            errors++; $display("FAIL err_mem got %h want 8001beef", mem[11'h040]);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd7);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_f3    = 3'b010;
        req_addr  = 32'h100;
        req_wdata = 32'hAAAA_AAAA;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8001_BEEF || rsp_rd !== 5'd7
                || req_ready !== 1'b0 || dmem_we !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d got v=%0b d=%h rd=%0d rdy=%0b we=%0b",
                         i, rsp_valid, rsp_rdata, rsp_rd, req_ready, dmem_we);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        consume();
        issue(1'b0, 3'b100, 32'h102, 32'h0, 5'd8);
        checks++;
        if (r_valid !== 1'b1 || r_rdata !== 32'h0000_0001 || r_rd !== 5'd8) begin
            errors++;
            $display("FAIL after_hold got %0b/%h/%0d want 1/00000001/8",
                     r_valid, r_rdata, r_rd);
        end
        consume();
    endtask

    task automatic test_reset_access();
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_f3    = 3'b010;
        req_addr  = 32'h200;
        req_wdata = 32'h1122_3344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (dmem_we !== 1'b1) begin
            errors++; $display("FAIL rstacc_pre got %0b want 1", dmem_we);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (dmem_we !== 1'b0 || dmem_sel !== 4'b0) begin
            errors++;
            $display("FAIL rstacc_drop got %0b/%b want 0/0000", dmem_we, dmem_sel);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (mem[11'h080] !== 32'd0) begin
            errors++; $display("FAIL rstacc_mem got %h want 0", mem[11'h080]);
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dmem_addr !== 11'd0) begin
            errors++;
            $display("FAIL rstacc_idle got %0b/%0b/%h want 1/0/0",
                     req_ready, rsp_valid, dmem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
